crc_request_scheduler: RTL

- Shares one transmitter_crc engine between two requesters: req 0 is the transmit packetizer, req 1 is the receive-side checker.
- Arbitrates round-robin, latches the winner's address/data, and pulses the engine's start for one cycle.
- Waits for the engine's done, or for a timeout, then returns the 16-bit CRC to the granted requester with a one-cycle ack.
- Sits between the packet framing logic and the CRC engine; it is the only driver of the engine's start, tr_data and tr_address inputs.

---
 rtl/crc_request_scheduler_if.sv | 33 +++
 rtl/crc_request_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/crc_request_scheduler_if.sv
// Requester and CRC-engine signals of the scheduler, bundled for port connection.
// The scheduler uses the slave view; the surrounding logic uses the master view.
interface crc_request_scheduler_if;
    logic        req0;
    logic [18:0] addr0;
    logic [35:0] data0;
    logic        req1;
    logic [18:0] addr1;
    logic [35:0] data1;
    logic        ack0;
    logic        ack1;
    logic [15:0] result;
    logic        err;
    logic        ready;
    logic        busy_id;
    logic        crc_start;
    logic [18:0] crc_tr_address;
    logic [35:0] crc_tr_data;
    logic        crc_done;
    logic [15:0] crc_r;

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, crc_done, crc_r,
        output ack0, ack1, result, err, ready, busy_id,
               crc_start, crc_tr_address, crc_tr_data
    );

    modport master (
        output req0, addr0, data0, req1, addr1, data1, crc_done, crc_r,
        input  ack0, ack1, result, err, ready, busy_id,
               crc_start, crc_tr_address, crc_tr_data
    );
endinterface

// File: rtl/crc_request_scheduler.sv
// Round-robin scheduler sharing one CRC engine between the transmit packetizer (req 0)
// and the receive checker (req 1), with post-reset engine drain and a WAIT timeout.
module crc_request_scheduler #(
    parameter int TIMEOUT      = 128,  // must exceed the engine's 56-cycle job
    parameter int FLUSH_CYCLES = 64    // must cover one full in-flight engine job
) (
    input  logic                    clock,
    input  logic                    reset,
    crc_request_scheduler_if.slave  bus
);
    localparam int CNT_MAX = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             busy_id_q, busy_id_d;
    logic [18:0]      addr_q, addr_d;
    logic [35:0]      data_q, data_d;
    logic [15:0]      result_q, result_d;
    logic             err_q, err_d;
    logic             grant_valid;
    logic             grant_id;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FLUSH;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            busy_id_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            busy_id_q    <= busy_id_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // One counter serves both the post-reset drain and the WAIT timer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        busy_id_d    = busy_id_q;
        addr_d       = addr_q;
        data_d       = data_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (grant_valid) begin
                    busy_id_d = grant_id;
                    addr_d    = grant_id ? bus.addr1 : bus.addr0;
                    data_d    = grant_id ? bus.data1 : bus.data0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done is tested first so a coincident timeout still returns the CRC
                if (bus.crc_done) begin
                    result_d = bus.crc_r;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == TIMER_LAST) begin
                    result_d = 16'h0000;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = busy_id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    assign bus.ready          = (state_q == S_IDLE);
    assign bus.crc_start      = (state_q == S_LAUNCH);
    assign bus.ack0           = (state_q == S_RESP) && !busy_id_q;
    assign bus.ack1           = (state_q == S_RESP) &&  busy_id_q;
    assign bus.busy_id        = busy_id_q;
    assign bus.result         = result_q;
    assign bus.err            = err_q;
    assign bus.crc_tr_address = addr_q;
    assign bus.crc_tr_data    = data_q;
endmodule
